bsg_lru_pseudo_tree_tracker: RTL
================================

Name: bsg_lru_pseudo_tree_tracker

Overview:
- Stateful pseudo-LRU tracker for a set-associative cache; it is the update side of the tree-PLRU encoder.
- On each touch (hit or fill) it decodes the touched way id into per-node bit updates and writes them into a per-set tree-bit array.
- On each query it returns the victim way for a set, registered, with forwarding of in-flight touches.
- Sits beside the tag array in cache controllers and feeds the replacement-way mux.

Parameters:
- ways_p, 64, associativity; power of 2, >=2.
- sets_p, 16, number of tracked sets; >=1.
- lg_ways_lp, clog2(ways_p), derived; way id width.
- lg_sets_lp, max(1, clog2(sets_p)), derived; set index width.

Ports:
- clk_i  input  1  clock
- reset_i  input  1  asynchronous active-high reset
- touch_v_i  input  1  touch valid; always accepted, no ready
- touch_set_i  input  lg_sets_lp  set being touched
- touch_way_i  input  lg_ways_lp  way being touched (becomes MRU)
- query_v_i  input  1  victim query valid
- query_set_i  input  lg_sets_lp  set being queried
- victim_v_o  output  1  victim response valid
- victim_way_o  output  lg_ways_lp  PLRU victim way for the queried set
- victim_lru_o  output  ways_p-1  tree bits of the queried set, with forwarding applied

Behaviour:
- Tree layout is heap order. Node 0 is the root; the children of node n are 2n+1 and 2n+2.
- Rank r holds nodes (2^r - 1) .. (2^(r+1) - 2).
- A node bit value of 0 points the LRU path to the left subtree; 1 points it right.
- Victim encode:
  - way_id[msb] = bit[0].
  - Rank r bit = bit[(2^r - 1) + way_id[msb:msb-r+1]].
- Touch decode for way w:
  - Exactly one node per rank is on the path of w; there are lg_ways_lp nodes in total.
  - Each path node at rank r is written to ~w[msb-r], pointing away from w.
  - All other bits of that set, and all bits of other sets, are unchanged.
  - This is a masked write; no read of the array is needed.
- Touch pipeline:
  - A touch presented in cycle T is captured in stage-1 registers (valid, set, way) at the end of T.
  - In T+1, the decoded mask/data is written to the array at the end of T+1.
- Touches on consecutive cycles, same or different sets, are all applied in presentation order.
  - No stalls and no lost updates.
  - A later touch overrides an earlier one on shared path nodes.
- Query timing:
  - query_v_i in cycle T produces victim_v_o=1 in T+1, with victim_way_o and victim_lru_o registered.
  - The response reflects every touch presented in cycles strictly before T.
  - A touch presented in the same cycle T is not reflected.
- Forwarding: during T, the array read for query_set_i is overlaid with the stage-1 mask/data when stage-1 is valid and its set matches.
- victim_v_o is 0 in any cycle following a cycle with query_v_i=0.
  - victim_way_o and victim_lru_o hold their last values when victim_v_o=0.
- Simultaneous touch and query to the same set in the same cycle is legal. The query returns the pre-touch victim.
- ways_p=2: one tree bit.
  - The victim is bit[0].
  - A touch writes bit[0] = ~w.
- Out-of-range touch_set_i or query_set_i (only possible when sets_p is not a power of 2) is a protocol error.
  - Behaviour is unspecified; the bench asserts this never occurs.
- Reset (asynchronous, effective immediately, including mid-pipeline):
  - All array bits = 0.
  - Stage-1 valid = 0, so any pending touch is dropped.
  - victim_v_o = 0, victim_way_o = 0, victim_lru_o = 0.
  - After reset every set's victim is way 0.

Test Plan:
- Reset, then query set 3 -> next cycle victim_v_o=1, victim_way_o=0, victim_lru_o=0.
- Touch set 3 way 0, idle 2 cycles, query set 3 -> victim_way_o=32; bits 0,1,3,7,15,31 set, all others 0. A query of set 4 returns 0.
- Touch set 3 way 0, then way 32 on the next cycle, idle, query set 3 -> victim_way_o=16.
- Forwarding: touch set 3 way 0 in cycle T.
  - Query set 3 in T+1 -> 32.
  - Query set 3 in T instead -> 0.
- Touch all 64 ways of set 5 in order 0..63 back-to-back, then query -> victim_way_o=0. Random touch/query streams are checked against a cycle-accurate reference model.
- Assert reset while a touch is in stage 1 and a query response is pending -> outputs are 0 immediately, the touch is not applied, and a later query returns 0.

Source files
------------

// File: rtl/bsg_lru_pseudo_tree_tracker.sv
// Per-set tree-PLRU state: touches become masked path writes, queries return the registered victim way.
// Touch written one cycle after capture, query answered next cycle with in-flight forwarding; always accepts, no backpressure.
module bsg_lru_pseudo_tree_tracker #(
    parameter int ways_p = 64,
    parameter int sets_p = 16,
    localparam int lg_ways_lp = $clog2(ways_p),
    localparam int lg_sets_lp = (sets_p > 1) ? $clog2(sets_p) : 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  touch_v_i,
    input  logic [lg_sets_lp-1:0] touch_set_i,
    input  logic [lg_ways_lp-1:0] touch_way_i,
    input  logic                  query_v_i,
    input  logic [lg_sets_lp-1:0] query_set_i,
    output logic                  victim_v_o,
    output logic [lg_ways_lp-1:0] victim_way_o,
    output logic [ways_p-2:0]     victim_lru_o
);

    logic [ways_p-2:0]     tree_q [sets_p];

    logic                  s1_v_q;
    logic [lg_sets_lp-1:0] s1_set_q;
    logic [lg_ways_lp-1:0] s1_way_q;

    logic [ways_p-2:0]     s1_mask;
    logic [ways_p-2:0]     s1_data;
    logic [lg_ways_lp-1:0] dec_prefix;

    logic [ways_p-2:0]     rd_lru;
    logic [ways_p-2:0]     fwd_lru;
    logic [lg_ways_lp-1:0] enc_prefix;

    logic                  victim_v_q;
    logic [lg_ways_lp-1:0] victim_way_q, victim_way_d;
    logic [ways_p-2:0]     victim_lru_q, victim_lru_d;

    // Heap index of the rank-r node reached by following the way-id prefix.
    function automatic logic [lg_ways_lp-1:0] node_idx(input int r, input logic [lg_ways_lp-1:0] prefix);
        return lg_ways_lp'((1 << r) - 1) + prefix;
    endfunction

    always_comb begin
        s1_mask    = '0;
        s1_data    = '0;
        dec_prefix = '0;
        for (int r = 0; r < lg_ways_lp; r++) begin
            s1_mask[node_idx(r, dec_prefix)] = 1'b1;
            s1_data[node_idx(r, dec_prefix)] = ~s1_way_q[lg_ways_lp-1-r];
            dec_prefix = (dec_prefix << 1) | lg_ways_lp'(s1_way_q[lg_ways_lp-1-r]);
        end
    end

    always_comb begin
        rd_lru = '0;
        for (int s = 0; s < sets_p; s++) begin
            if (query_set_i == lg_sets_lp'(s)) begin
                rd_lru = tree_q[s];
            end
        end
    end

    // The touch still sitting in stage 1 has not reached the array yet; overlay it.
    assign fwd_lru = (s1_v_q && (s1_set_q == query_set_i))
                   ? ((rd_lru & ~s1_mask) | (s1_data & s1_mask))
                   : rd_lru;

    always_comb begin
        enc_prefix = '0;
        for (int r = 0; r < lg_ways_lp; r++) begin
            enc_prefix = (enc_prefix << 1) | lg_ways_lp'(fwd_lru[node_idx(r, enc_prefix)]);
        end
        victim_way_d = enc_prefix;
        victim_lru_d = fwd_lru;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s1_v_q   <= 1'b0;
            s1_set_q <= '0;
            s1_way_q <= '0;
        end else begin
            s1_v_q   <= touch_v_i;
            s1_set_q <= touch_set_i;
            s1_way_q <= touch_way_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int s = 0; s < sets_p; s++) begin
                tree_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < sets_p; s++) begin
                if (s1_v_q && (s1_set_q == lg_sets_lp'(s))) begin
                    tree_q[s] <= (tree_q[s] & ~s1_mask) | (s1_data & s1_mask);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            victim_v_q   <= 1'b0;
            victim_way_q <= '0;
            victim_lru_q <= '0;
        end else begin
            victim_v_q <= query_v_i;
            if (query_v_i) begin
                victim_way_q <= victim_way_d;
                victim_lru_q <= victim_lru_d;
            end
        end
    end

    assign victim_v_o   = victim_v_q;
    assign victim_way_o = victim_way_q;
    assign victim_lru_o = victim_lru_q;

endmodule
